// File: rtl/jesd204_tx_gearbox_ctrl_pkg.sv
// Shared JESD204 TX definitions: sequencer state encodings and status bit positions
// used by the gearbox control block and the register map.
package jesd204_tx_gearbox_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_ARM        = 3'd2,
        ST_RUN        = 3'd3
    } gearbox_state_t;

    localparam int STATUS_LMFC_ERR_BIT    = 0;
    localparam int STATUS_READY_DROP_BIT  = 1;
    localparam int STATUS_ALIGN_COUNT_LSB = 8;
    localparam int ALIGN_COUNT_W          = 8;

    function automatic logic [ALIGN_COUNT_W-1:0] sat_inc(input logic [ALIGN_COUNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/jesd204_lmfc_period_check.sv
// LMFC edge periodicity supervisor: counts device beats between edges and pulses
// period_err when an edge arrives off-period. Shared with the RX side.
module jesd204_lmfc_period_check #(
    parameter int CNT_W = 8
) (
    input  logic             device_clk,
    input  logic             reset,
    input  logic             active,
    input  logic             lmfc_edge,
    input  logic [CNT_W-1:0] period,
    output logic             period_err
);

    logic [CNT_W-1:0] beat_cnt;
    logic             seen;

    // The first edge after activation only arms the check; there is no prior edge to measure from.
    always_ff @(posedge device_clk) begin
        if (reset) begin
            beat_cnt <= '0;
            seen     <= 1'b0;
        end else begin
            if (lmfc_edge)
                beat_cnt <= '0;
            else if (beat_cnt != '1)
                beat_cnt <= beat_cnt + 1'b1;

            if (!active)
                seen <= 1'b0;
            else if (lmfc_edge)
                seen <= 1'b1;
        end
    end

    assign period_err = active && lmfc_edge && seen &&
                        (period != '0) && (beat_cnt != period - 1'b1);

endmodule

// File: rtl/jesd204_tx_gearbox_ctrl.sv
// Device-clock sequencer for the JESD204 TX gearbox: releases the write pointer on an
// LMFC boundary once the link is ready, then enables sample data after a start delay.
module jesd204_tx_gearbox_ctrl
    import jesd204_tx_gearbox_ctrl_pkg::*;
#(
    parameter int LMFC_CNT_W = 8,
    parameter int DELAY_W    = 8
) (
    input  logic                  device_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  device_lmfc_edge,
    input  logic                  link_ready_sync,
    input  logic [LMFC_CNT_W-1:0] cfg_lmfc_period,
    input  logic [DELAY_W-1:0]    cfg_start_delay,
    input  logic                  cfg_auto_realign,
    input  logic                  clr_status,
    output logic                  gearbox_addr_reset,
    output logic                  device_data_enable,
    output logic [2:0]            status_state,
    output logic                  status_lmfc_err,
    output logic                  status_ready_drop,
    output logic [7:0]            status_align_count
);

    gearbox_state_t     state;
    gearbox_state_t     next_state;
    logic [DELAY_W-1:0] delay_cnt;
    logic               period_err;
    logic               set_ready_drop;
    logic               align_done;

    jesd204_lmfc_period_check #(
        .CNT_W (LMFC_CNT_W)
    ) u_period_check (
        .device_clk (device_clk),
        .reset      (reset),
        .active     (state != ST_IDLE),
        .lmfc_edge  (device_lmfc_edge),
        .period     (cfg_lmfc_period),
        .period_err (period_err)
    );

    // enable=0 overrides everything; a ready drop outranks the ARM terminal count.
    always_comb begin
        next_state     = state;
        set_ready_drop = 1'b0;
        align_done     = 1'b0;
        if (!enable) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: next_state = ST_WAIT_READY;
                ST_WAIT_READY: begin
                    if (device_lmfc_edge && link_ready_sync)
                        next_state = ST_ARM;
                end
                ST_ARM: begin
                    if (!link_ready_sync) begin
                        next_state     = ST_WAIT_READY;
                        set_ready_drop = 1'b1;
                    end else if (delay_cnt == cfg_start_delay) begin
                        next_state = ST_RUN;
                        align_done = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!link_ready_sync) begin
                        next_state     = ST_WAIT_READY;
                        set_ready_drop = 1'b1;
                    end else if (period_err && cfg_auto_realign) begin
                        next_state = ST_WAIT_READY;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Outputs decode next_state so they move on the same edge as the state register.
    always_ff @(posedge device_clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            delay_cnt          <= '0;
            gearbox_addr_reset <= 1'b1;
            device_data_enable <= 1'b0;
        end else begin
            state              <= next_state;
            delay_cnt          <= (state == ST_ARM) ? delay_cnt + 1'b1 : '0;
            gearbox_addr_reset <= !((next_state == ST_ARM) || (next_state == ST_RUN));
            device_data_enable <= (next_state == ST_RUN);
        end
    end

    // Sticky status: a set in the same cycle as clr_status wins.
    always_ff @(posedge device_clk) begin
        if (reset) begin
            status_lmfc_err    <= 1'b0;
            status_ready_drop  <= 1'b0;
            status_align_count <= '0;
        end else begin
            if (period_err)
                status_lmfc_err <= 1'b1;
            else if (clr_status)
                status_lmfc_err <= 1'b0;

            if (set_ready_drop)
                status_ready_drop <= 1'b1;
            else if (clr_status)
                status_ready_drop <= 1'b0;

            if (align_done)
                status_align_count <= sat_inc(status_align_count);
        end
    end

    assign status_state = state;

endmodule

// File: tb/tb_jesd204_tx_gearbox_ctrl.sv
// Directed bench for the TX gearbox sequencer: start-up alignment, ready drops,
// LMFC period errors, sticky status clearing, enable abort and reset mid-run.
module tb_jesd204_tx_gearbox_ctrl;

    logic       device_clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       device_lmfc_edge;
    logic       link_ready_sync;
    logic [7:0] cfg_lmfc_period;
    logic [7:0] cfg_start_delay;
    logic       cfg_auto_realign;
    logic       clr_status;
    logic       gearbox_addr_reset;
    logic       device_data_enable;
    logic [2:0] status_state;
    logic       status_lmfc_err;
    logic       status_ready_drop;
    logic [7:0] status_align_count;

    int checksTotal  = 0;
    int checksPassed = 0;

    jesd204_tx_gearbox_ctrl #(
        .LMFC_CNT_W (8),
        .DELAY_W    (8)
    ) dut (
        .device_clk         (device_clk),
        .reset              (reset),
        .enable             (enable),
        .device_lmfc_edge   (device_lmfc_edge),
        .link_ready_sync    (link_ready_sync),
        .cfg_lmfc_period    (cfg_lmfc_period),
        .cfg_start_delay    (cfg_start_delay),
        .cfg_auto_realign   (cfg_auto_realign),
        .clr_status         (clr_status),
        .gearbox_addr_reset (gearbox_addr_reset),
        .device_data_enable (device_data_enable),
        .status_state       (status_state),
        .status_lmfc_err    (status_lmfc_err),
        .status_ready_drop  (status_ready_drop),
        .status_align_count (status_align_count)
    );

    always #5 device_clk = ~device_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        if (observed === expected)
            checksPassed++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge device_clk);
            #1;
        end
    endtask

    task automatic applyStimulus();
        device_lmfc_edge = 1'b1;
        tick(1);
        device_lmfc_edge = 1'b0;
    endtask

    task automatic pulseClear();
        clr_status = 1'b1;
        tick(1);
        clr_status = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        enable           = 1'b0;
        device_lmfc_edge = 1'b0;
        link_ready_sync  = 1'b0;
        cfg_lmfc_period  = 8'd16;
        cfg_start_delay  = 8'd4;
        cfg_auto_realign = 1'b1;
        clr_status       = 1'b0;
        tick(3);
        checkOutput("reset_state", status_state, 0);
        checkOutput("reset_addr_reset", gearbox_addr_reset, 1);
        checkOutput("reset_data_enable", device_data_enable, 0);
        checkOutput("reset_lmfc_err", status_lmfc_err, 0);
        checkOutput("reset_ready_drop", status_ready_drop, 0);
        checkOutput("reset_align_count", status_align_count, 0);

        reset  = 1'b0;
        enable = 1'b1;
        tick(1);
        checkOutput("enter_wait_ready", status_state, 1);

        // Three edges without ready: must stay parked
        for (int e = 0; e < 3; e++) begin
            applyStimulus();
            tick(15);
        end
        checkOutput("no_ready_state", status_state, 1);
        checkOutput("no_ready_addr_reset", gearbox_addr_reset, 1);

        link_ready_sync = 1'b1;
        applyStimulus();
        checkOutput("arm_state", status_state, 2);
        checkOutput("arm_addr_reset", gearbox_addr_reset, 0);
        tick(4);
        checkOutput("arm_delay_state", status_state, 2);
        checkOutput("arm_delay_data_enable", device_data_enable, 0);
        tick(1);
        checkOutput("run_state", status_state, 3);
        checkOutput("run_data_enable", device_data_enable, 1);
        checkOutput("run_align_count_1", status_align_count, 1);
        checkOutput("run_lmfc_err_clean", status_lmfc_err, 0);

        tick(10);
        applyStimulus();
        checkOutput("on_period_edge_err", status_lmfc_err, 0);
        checkOutput("on_period_edge_state", status_state, 3);

        // Ready drop in RUN
        tick(3);
        link_ready_sync = 1'b0;
        tick(1);
        checkOutput("drop_state", status_state, 1);
        checkOutput("drop_addr_reset", gearbox_addr_reset, 1);
        checkOutput("drop_data_enable", device_data_enable, 0);
        checkOutput("drop_sticky", status_ready_drop, 1);
        link_ready_sync = 1'b1;
        tick(11);
        applyStimulus();
        checkOutput("realign_arm", status_state, 2);
        tick(5);
        checkOutput("realign_run", status_state, 3);
        checkOutput("realign_align_count_2", status_align_count, 2);

        // Sticky clear alone, then clear colliding with a new drop
        pulseClear();
        checkOutput("clr_alone_drop", status_ready_drop, 0);
        link_ready_sync = 1'b0;
        clr_status      = 1'b1;
        tick(1);
        clr_status      = 1'b0;
        link_ready_sync = 1'b1;
        checkOutput("clr_vs_set_drop", status_ready_drop, 1);
        checkOutput("clr_vs_set_state", status_state, 1);
        pulseClear();
        checkOutput("clr_second_drop", status_ready_drop, 0);
        tick(7);
        applyStimulus();
        tick(5);
        checkOutput("align_count_3", status_align_count, 3);

        // Short LMFC period (12 beats) with auto realign
        tick(6);
        applyStimulus();
        checkOutput("short_period_err_auto", status_lmfc_err, 1);
        checkOutput("short_period_state_auto", status_state, 1);
        checkOutput("short_period_addr_reset", gearbox_addr_reset, 1);
        pulseClear();
        checkOutput("clr_lmfc_err", status_lmfc_err, 0);
        tick(14);
        applyStimulus();
        tick(5);
        checkOutput("align_count_4", status_align_count, 4);

        // Short period without auto realign: flag only
        cfg_auto_realign = 1'b0;
        tick(6);
        applyStimulus();
        checkOutput("short_period_err_noauto", status_lmfc_err, 1);
        checkOutput("short_period_state_noauto", status_state, 3);
        checkOutput("short_period_de_noauto", device_data_enable, 1);
        pulseClear();

        // Period check disabled
        cfg_lmfc_period = 8'd0;
        tick(5);
        applyStimulus();
        checkOutput("period_zero_no_err", status_lmfc_err, 0);
        checkOutput("period_zero_state", status_state, 3);
        cfg_lmfc_period = 8'd16;
        tick(15);
        applyStimulus();
        checkOutput("period_restored_no_err", status_lmfc_err, 0);

        // enable=0 during a long ARM delay
        enable = 1'b0;
        tick(1);
        checkOutput("disable_idle", status_state, 0);
        cfg_start_delay = 8'd200;
        enable = 1'b1;
        tick(1);
        applyStimulus();
        tick(10);
        checkOutput("long_arm_state", status_state, 2);
        checkOutput("long_arm_data_enable", device_data_enable, 0);
        enable = 1'b0;
        tick(1);
        checkOutput("abort_arm_state", status_state, 0);
        checkOutput("abort_arm_addr_reset", gearbox_addr_reset, 1);
        checkOutput("abort_arm_data_enable", device_data_enable, 0);
        checkOutput("abort_arm_align_count", status_align_count, 4);

        // D=0 with an off-period edge on the ARM terminal cycle: RUN anyway, error flagged
        cfg_start_delay  = 8'd0;
        cfg_auto_realign = 1'b1;
        enable = 1'b1;
        tick(1);
        applyStimulus();
        checkOutput("d0_arm", status_state, 2);
        applyStimulus();
        checkOutput("d0_terminal_edge_run", status_state, 3);
        checkOutput("d0_terminal_edge_de", device_data_enable, 1);
        checkOutput("d0_terminal_edge_err", status_lmfc_err, 1);
        checkOutput("d0_align_count_5", status_align_count, 5);

        // Reset mid-RUN
        reset = 1'b1;
        tick(1);
        checkOutput("midrun_reset_state", status_state, 0);
        checkOutput("midrun_reset_addr_reset", gearbox_addr_reset, 1);
        checkOutput("midrun_reset_de", device_data_enable, 0);
        checkOutput("midrun_reset_err", status_lmfc_err, 0);
        checkOutput("midrun_reset_align", status_align_count, 0);
        reset = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
